fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline. Sits directly upstream of decode.
- Owns the PC register and a single-outstanding request/response instruction-memory interface.
- Owns the IF/ID pipeline register that drives decode's pc, instruction and pcPlus4 inputs.
- Honours hazard-unit stalls and EX-stage redirects (taken branch/jump), discarding stale in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on reset/flush.

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-low reset
stall_IF  input  1  hazard unit: hold PC and IF/ID contents
pcSrc_EX  input  1  redirect request from EX (taken branch/jump)
pcTarget_EX  input  32  redirect target
imem_req  output  1  fetch request, one-cycle pulse per request, always accepted
imem_addr  output  32  fetch address, valid when imem_req=1
imem_rdata  input  32  fetched instruction
imem_rvalid  input  1  response strobe, ≥1 cycle after its request
pc_ID  output  32  IF/ID: PC of instruction
instr_ID  output  32  IF/ID: instruction
pcPlus4_ID  output  32  IF/ID: pc_ID+4
valid_ID  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst=0, async):
  - pc_reg=RESET_PC; state=FETCH; skid buffer empty.
  - pc_ID=0, pcPlus4_ID=0, instr_ID=NOP_INSTR, valid_ID=0.
  - imem_req=0 while rst=0.
- States: FETCH, WAIT, HOLD, DISCARD.
- FETCH:
  - imem_req=1, imem_addr=pc_reg, unless pcSrc_EX=1.
  - On issue -> WAIT.
- WAIT, imem_rvalid=1, stall_IF=0:
  - IF/ID <= {pc_reg, imem_rdata, pc_reg+4}, valid_ID<=1; pc_reg<=pc_reg+4.
  - Same cycle, imem_req=1 with imem_addr=pc_reg+4 (combinational); stay WAIT.
  - Throughput: 1 instr/cycle with a 1-cycle memory.
- WAIT, imem_rvalid=1, stall_IF=1:
  - Capture rdata in skid buffer; IF/ID held; no new request -> HOLD.
- WAIT, imem_rvalid=0: stay WAIT. IF/ID held if stall_IF=1; otherwise valid_ID<=0 and instr_ID<=NOP_INSTR (bubble).
- HOLD:
  - While stall_IF=1: hold.
  - When stall_IF=0: IF/ID <= skid contents (pc_reg, pc_reg+4); pc_reg+=4 -> FETCH.
- Redirect (pcSrc_EX=1) has highest priority in every state, including over stall_IF:
  - pc_reg <= {pcTarget_EX[31:2],2'b00}.
  - IF/ID <= NOP bubble, valid_ID<=0.
  - Skid buffer cleared; no request issued that cycle.
  - FETCH or HOLD -> FETCH.
  - WAIT with imem_rvalid=1 -> FETCH (response dropped).
  - WAIT with imem_rvalid=0 -> DISCARD.
  - DISCARD: stay unless imem_rvalid=1 that cycle, then -> FETCH.
- DISCARD: next imem_rvalid is dropped, no IF/ID update -> FETCH. Stall does not affect the dropping.
- Arithmetic: PC +4 is modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000. PC bits [1:0] are always 0.
- Never more than one outstanding request.
- imem_rvalid in FETCH or HOLD is a protocol error: ignore it. The bench asserts it never occurs.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds two outputs, both cleared on reset, saturating at 32'hFFFF_FFFF:
  - fetch_count_IF (32): increments on each IF/ID load with valid_ID=1.
  - redirect_count_IF (32): increments each cycle pcSrc_EX=1.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release, RESET_PC=0, 1-cycle memory, no stalls -> imem_addr 0x0,0x4,0x8 on consecutive cycles; pc_ID 0x0,0x4,0x8 with pcPlus4_ID 0x4,0x8,0xC; valid_ID=1 every cycle after first response.
- stall_IF=1 for 3 cycles as instruction at 0x8 returns -> IF/ID holds 0x4 entry; HOLD entered; no imem_req. After release, pc_ID=0x8 with the captured instr; fetch resumes at 0xC.
- pcSrc_EX=1, pcTarget_EX=0x100 while a 3-cycle-latency fetch of 0x10 is in flight -> DISCARD; valid_ID=0, instr_ID=0x00000013; 0x10 response dropped; next imem_addr=0x100; pc_ID=0x100 on its return.
- pcSrc_EX=1 coinciding with imem_rvalid and stall_IF=1 -> response dropped; bubble in IF/ID; next request 0x100-class target; no HOLD.
- RESET_PC=0xFFFF_FFFC -> pcPlus4_ID=0x0; next imem_addr=0x0. pcTarget_EX=0x203 -> imem_addr=0x200.
- rst asserted mid-WAIT -> outputs return to reset values immediately (async). Late imem_rvalid after release is not issued as an instruction (bench keeps memory idle across reset). With IF_PERF_EN-style macro IF_PERF_CNT_EN: counters read 0 after reset, fetch_count_IF=3 after three delivered instructions.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RISC-V IF stage: PC, single-outstanding imem fetch, IF/ID register.
// Optional IF_PERF_CNT_EN adds saturating fetch/redirect counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_IF,
  input  logic        pcSrc_EX,
  input  logic [31:0] pcTarget_EX,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] pc_ID,
  output logic [31:0] instr_ID,
  output logic [31:0] pcPlus4_ID,
  output logic        valid_ID
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count_IF,
  output logic [31:0] redirect_count_IF
`endif
);

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, skid_q, skid_d;
  logic [31:0] pc_id_q, pc_id_d, instr_id_q, instr_id_d, pcp4_id_q, pcp4_id_d;
  logic        valid_id_q, valid_id_d;
  logic        issue, deliver;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    pc_id_d    = pc_id_q;
    instr_id_d = instr_id_q;
    pcp4_id_d  = pcp4_id_q;
    valid_id_d = valid_id_q;
    issue      = 1'b0;
    deliver    = 1'b0;
    if (pcSrc_EX) begin
      // A fetch still in flight must have its response swallowed in DISCARD.
      pc_d       = pcTarget_EX & 32'hFFFF_FFFC;
      instr_id_d = NOP_INSTR;
      valid_id_d = 1'b0;
      skid_d     = NOP_INSTR;
      state_d    = ((state_q == S_WAIT || state_q == S_DISCARD) && !imem_rvalid) ? S_DISCARD : S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          issue   = 1'b1;
          state_d = S_WAIT;
          if (!stall_IF) begin
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid && !stall_IF) begin
            deliver    = 1'b1;
            instr_id_d = imem_rdata;
            issue      = 1'b1;
          end else if (imem_rvalid) begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end else if (!stall_IF) begin
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall_IF) begin
            deliver    = 1'b1;
            instr_id_d = skid_q;
            state_d    = S_FETCH;
          end
        end
        S_DISCARD: begin
          if (imem_rvalid) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
      if (deliver) begin
        pc_id_d    = pc_q;
        pcp4_id_d  = pc_plus4;
        valid_id_d = 1'b1;
        pc_d       = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      skid_q     <= NOP_INSTR;
      pc_id_q    <= 32'd0;
      instr_id_q <= NOP_INSTR;
      pcp4_id_q  <= 32'd0;
      valid_id_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      skid_q     <= skid_d;
      pc_id_q    <= pc_id_d;
      instr_id_q <= instr_id_d;
      pcp4_id_q  <= pcp4_id_d;
      valid_id_q <= valid_id_d;
    end
  end

  // The follow-on request in WAIT goes out in the same cycle its predecessor returns.
  assign imem_req   = rst & issue;
  assign imem_addr  = (state_q == S_FETCH) ? pc_q : pc_plus4;
  assign pc_ID      = pc_id_q;
  assign instr_ID   = instr_id_q;
  assign pcPlus4_ID = pcp4_id_q;
  assign valid_ID   = valid_id_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, redir_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= 32'd0;
      redir_cnt_q <= 32'd0;
    end else begin
      if (deliver && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (pcSrc_EX && redir_cnt_q != 32'hFFFF_FFFF) redir_cnt_q <= redir_cnt_q + 32'd1;
    end
  end

  assign fetch_count_IF    = fetch_cnt_q;
  assign redirect_count_IF = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - Self-checking bench for fetch_stage with a transaction-level fetch model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall_IF, pcSrc_EX, imem_req, imem_rvalid, valid_ID;
  logic [31:0] pcTarget_EX, imem_addr, imem_rdata, pc_ID, instr_ID, pcPlus4_ID;
  logic        w_req, w_rvalid, w_valid;
  logic [31:0] w_addr, w_rdata, w_pc_ID, w_instr_ID, w_pcp4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fc, rc, w_fc, w_rc;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .rst(rst), .stall_IF(stall_IF), .pcSrc_EX(pcSrc_EX), .pcTarget_EX(pcTarget_EX),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .pc_ID(pc_ID), .instr_ID(instr_ID), .pcPlus4_ID(pcPlus4_ID), .valid_ID(valid_ID)
`ifdef IF_PERF_CNT_EN
    , .fetch_count_IF(fc), .redirect_count_IF(rc)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_wrap (
    .clk(clk), .rst(rst), .stall_IF(1'b0), .pcSrc_EX(1'b0), .pcTarget_EX(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata), .imem_rvalid(w_rvalid),
    .pc_ID(w_pc_ID), .instr_ID(w_instr_ID), .pcPlus4_ID(w_pcp4), .valid_ID(w_valid)
`ifdef IF_PERF_CNT_EN
    , .fetch_count_IF(w_fc), .redirect_count_IF(w_rc)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: next PC to deliver, one in-flight fetch (maybe stale), one held response.
  logic [31:0] m_pc, m_id_pc, m_id_instr, m_held_instr, m_fc, m_rc;
  bit          m_valid, m_inflight, m_stale, m_held;
  bit          mem_pend, w_pend;
  int          mem_cnt, mem_lat;
  logic [31:0] mem_a, w_a;
  logic [31:0] iss_q[$];
  logic [31:0] w_iss_q[$];
  int          n;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_id_pc = 32'h0; m_id_instr = NOP; m_valid = 0;
    m_inflight = 0; m_stale = 0; m_held = 0; m_fc = 0; m_rc = 0;
    mem_pend = 0; w_pend = 0;
  endtask

  task automatic load(input logic [31:0] ins);
    m_id_pc = m_pc; m_id_instr = ins; m_valid = 1;
    m_pc = m_pc + 32'd4;
    if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
  endtask

  task automatic bubble();
    m_valid = 0; m_id_instr = NOP;
  endtask

  task automatic eval_cycle();
    bit exp_req;
    logic [31:0] exp_addr;
    exp_req = 0; exp_addr = m_pc;
    if (rst && !pcSrc_EX) begin
      if (!m_inflight && !m_held) exp_req = 1;
      else if (m_inflight && !m_stale && imem_rvalid && !stall_IF) begin
        exp_req = 1; exp_addr = m_pc + 32'd4;
      end
    end
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, exp_addr);
    chk("valid_ID", valid_ID, m_valid);
    chk("instr_ID", instr_ID, m_id_instr);
    if (m_valid) begin
      chk("pc_ID", pc_ID, m_id_pc);
      chk("pcPlus4_ID", pcPlus4_ID, m_id_pc + 32'd4);
    end
`ifdef IF_PERF_CNT_EN
    chk("fetch_count_IF", fc, m_fc);
    chk("redirect_count_IF", rc, m_rc);
`endif
    if (imem_req) iss_q.push_back(imem_addr);
    if (w_req) w_iss_q.push_back(w_addr);
    if (!rst) model_reset();
    else begin
      if (pcSrc_EX) begin
        if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
        m_pc = pcTarget_EX & 32'hFFFF_FFFC;
        bubble();
        m_held = 0;
        if (m_inflight && !imem_rvalid) m_stale = 1;
        else begin m_inflight = 0; m_stale = 0; end
      end else if (m_held) begin
        if (!stall_IF) begin load(m_held_instr); m_held = 0; end
      end else if (!m_inflight) begin
        m_inflight = 1;
        if (!stall_IF) bubble();
      end else if (m_stale) begin
        if (imem_rvalid) begin m_inflight = 0; m_stale = 0; end
      end else if (imem_rvalid) begin
        if (!stall_IF) load(mem_word(m_pc));
        else begin m_held = 1; m_held_instr = mem_word(m_pc); m_inflight = 0; end
      end else if (!stall_IF) bubble();
      if (imem_rvalid) mem_pend = 0;
      if (imem_req) begin mem_pend = 1; mem_a = imem_addr; mem_cnt = mem_lat; end
      w_pend = w_req; w_a = w_addr;
    end
  endtask

  task automatic drive(input bit s, input bit p, input logic [31:0] t);
    stall_IF = s; pcSrc_EX = p; pcTarget_EX = t;
    if (mem_pend && mem_cnt > 0) mem_cnt--;
    imem_rvalid = mem_pend && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(mem_a) : $urandom;
    w_rvalid = w_pend;
    w_rdata  = mem_word(w_a);
  endtask

  task automatic step(input bit s, input bit p, input logic [31:0] t);
    drive(s, p, t);
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] t;
    rst = 1'b0; mem_lat = 1;
    model_reset();
    drive(0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst pc_ID", pc_ID, 32'h0);
    chk("rst pcPlus4_ID", pcPlus4_ID, 32'h0);
    chk("rst instr_ID", instr_ID, NOP);
    chk("rst valid_ID", valid_ID, 1'b0);
    chk("rst imem_req", imem_req, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("rst fetch_count", fc, 32'h0);
    chk("rst redirect_count", rc, 32'h0);
`endif
    rst = 1'b1;

    step(0, 0, 0);
    step(0, 0, 0);
    chk("seq pc_ID0", pc_ID, 32'h0);
    chk("seq pcPlus4_ID0", pcPlus4_ID, 32'h4);
    chk("wrap first addr", w_iss_q[0], 32'hFFFF_FFFC);
    chk("wrap pc_ID", w_pc_ID, 32'hFFFF_FFFC);
    chk("wrap pcPlus4_ID", w_pcp4, 32'h0);
    chk("wrap next addr", w_iss_q[1], 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("wrap fetch_count", w_fc, 32'h1);
    chk("wrap redirect_count", w_rc, 32'h0);
`endif
    step(0, 0, 0);
    chk("seq pc_ID1", pc_ID, 32'h4);
    chk("seq pcPlus4_ID1", pcPlus4_ID, 32'h8);
    chk("seq addr0", iss_q[0], 32'h0);
    chk("seq addr1", iss_q[1], 32'h4);
    chk("seq addr2", iss_q[2], 32'h8);

    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      chk("stall holds pc_ID", pc_ID, 32'h4);
      chk("stall holds valid", valid_ID, 1'b1);
      chk("stall no request", iss_q.size(), 3);
    end
    step(0, 0, 0);
    chk("release pc_ID", pc_ID, 32'h8);
    chk("release instr", instr_ID, mem_word(32'h8));
`ifdef IF_PERF_CNT_EN
    chk("fetch_count 3", fc, 32'd3);
`endif
    step(0, 0, 0);
    chk("resume addr", iss_q[$], 32'hC);

    mem_lat = 3;
    step(0, 0, 0);
    chk("slow fetch addr", iss_q[$], 32'h10);
    n = iss_q.size();
    step(0, 1, 32'h100);
    chk("redir valid", valid_ID, 1'b0);
    chk("redir instr", instr_ID, NOP);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("discard no issue", iss_q.size(), n);
    chk("discard valid", valid_ID, 1'b0);
    mem_lat = 1;
    step(0, 0, 0);
    chk("target addr", iss_q[$], 32'h100);
    step(0, 0, 0);
    chk("target pc_ID", pc_ID, 32'h100);
    chk("target instr", instr_ID, mem_word(32'h100));

    step(1, 1, 32'h203);
    chk("redir+stall valid", valid_ID, 1'b0);
    chk("redir+stall instr", instr_ID, NOP);
    step(1, 0, 0);
    chk("aligned target addr", iss_q[$], 32'h200);

    step(0, 0, 0);
    mem_lat = 3;
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 1'b0;
    #2;
    chk("async pc_ID", pc_ID, 32'h0);
    chk("async pcPlus4_ID", pcPlus4_ID, 32'h0);
    chk("async instr_ID", instr_ID, NOP);
    chk("async valid_ID", valid_ID, 1'b0);
    chk("async imem_req", imem_req, 1'b0);
    model_reset();
    mem_lat = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("post-reset pc_ID", pc_ID, 32'h0);
    chk("post-reset instr", instr_ID, mem_word(32'h0));

    for (int i = 0; i < 3000; i++) begin
      mem_lat = $urandom_range(1, 3);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
